// File: rtl/cgol_pkg.sv
// Shared types for the LED-matrix display path: frame geometry, row/frame storage, scan states.
package cgol_pkg;
  localparam int unsigned ROWS = 8;
  localparam int unsigned COLS = 8;

  typedef logic [COLS-1:0] row_t;
  typedef row_t frame_t [ROWS];

  typedef enum logic {
    SCAN  = 1'b0,
    BLANK = 1'b1
  } scan_state_e;
endpackage

// File: rtl/disp_scanner_frame_buf.sv
// Two-bank frame store: writes land in the back bank, reads come from the front bank.
// The read port looks through a same-cycle swap so registered consumers see the new front.
import cgol_pkg::*;

module frame_buf (
  input  logic       clk,
  input  logic       clear,
  input  logic       swap,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  row_t       wr_data,
  input  logic [2:0] rd_row,
  output row_t       rd_data_c
);
  frame_t banks [2];
  logic   front;

  always_ff @(posedge clk) begin
    if (clear) begin
      front <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < int'(ROWS); r++) begin
          banks[b][r] <= '0;
        end
      end
    end else begin
      if (swap) front <= ~front;
      if (wr_en) banks[~front][wr_row] <= wr_data;
    end
  end

  assign rd_data_c = banks[front ^ swap][rd_row];
endmodule

// File: rtl/disp_scanner.sv
// Double-buffered 8x8 frame store and row-scan sequencer for the LED matrix.
// Define DISP_SCANNER_BLANK_EN to insert BLANK_CYC blanking cycles after every row.
import cgol_pkg::*;

module disp_scanner #(
  parameter int unsigned DWELL     = 1024,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic       ph1,
  input  logic       reset_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic       wr_last,
  output logic [5:0] addr,
  output logic [7:0] bit_out,
  output logic       frame_start
);
  localparam int unsigned DW = $clog2(DWELL);

  scan_state_e   state;
  logic [DW-1:0] dwell;
  logic [2:0]    row;
  logic          swap_pending;

  logic       accept, end_dwell, boundary, swap, sp_nx;
  logic [2:0] row_nx, rd_row;
  row_t       rd_data;

  assign accept    = wr_valid & wr_ready;
  assign end_dwell = (state == SCAN) && (dwell == DW'(DWELL - 1));
  assign boundary  = end_dwell && (row == 3'd7);
  assign swap      = boundary && swap_pending;
  assign row_nx    = row + 3'd1;
  // Read the row that will be on display after this edge.
  assign rd_row    = end_dwell ? row_nx : row;
  // Swap wins over a new wr_last; wr_ready is low whenever swap_pending is set.
  assign sp_nx     = swap ? 1'b0 : (swap_pending | (accept & wr_last));

  frame_buf u_frame_buf (
    .clk       (ph1),
    .clear     (~reset_n),
    .swap      (swap),
    .wr_en     (accept),
    .wr_row    (wr_row),
    .wr_data   (wr_data),
    .rd_row    (rd_row),
    .rd_data_c (rd_data)
  );

`ifdef DISP_SCANNER_BLANK_EN
  localparam int unsigned BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  logic [BW-1:0] blank_cnt;
`endif

  always_ff @(posedge ph1) begin
    if (!reset_n) begin
      state        <= SCAN;
      dwell        <= '0;
      row          <= '0;
      swap_pending <= 1'b0;
      wr_ready     <= 1'b0;
      addr         <= '0;
      bit_out      <= '0;
      frame_start  <= 1'b0;
`ifdef DISP_SCANNER_BLANK_EN
      blank_cnt    <= '0;
`endif
    end else begin
      frame_start  <= 1'b0;
      swap_pending <= sp_nx;
      wr_ready     <= ~sp_nx;
      case (state)
        SCAN: begin
          if (end_dwell) begin
            dwell <= '0;
            row   <= row_nx;
            addr  <= {row_nx, 3'b000};
`ifdef DISP_SCANNER_BLANK_EN
            state     <= BLANK;
            blank_cnt <= '0;
            bit_out   <= '0;
`else
            bit_out     <= rd_data;
            frame_start <= boundary;
`endif
          end else begin
            dwell   <= dwell + DW'(1);
            bit_out <= rd_data;
          end
        end
`ifdef DISP_SCANNER_BLANK_EN
        BLANK: begin
          if (blank_cnt == BW'(BLANK_CYC - 1)) begin
            state       <= SCAN;
            bit_out     <= rd_data;
            frame_start <= (row == 3'd0);
          end else begin
            blank_cnt <= blank_cnt + BW'(1);
          end
        end
`endif
        default: state <= SCAN;
      endcase
    end
  end
endmodule
